// File: rtl/led_pattern_gen_if.sv
// Control and status bundle for led_pattern_gen: start/abort, run configuration,
// and the registered LED pattern with busy/done status.
interface led_pattern_gen_if #(
  parameter int WIDTH = 10,
  parameter int DIV_W = 16,
  parameter int REP_W = 4
);
  logic             won;
  logic             stop;
  logic [1:0]       mode;
  logic [DIV_W-1:0] period;
  logic [REP_W-1:0] repeats;
  logic [WIDTH-1:0] LEDR;
  logic             busy;
  logic             done;

  modport master (
    output won, stop, mode, period, repeats,
    input  LEDR, busy, done
  );

  modport slave (
    input  won, stop, mode, period, repeats,
    output LEDR, busy, done
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: plays BLINK/CHASE/FILL/ALT patterns, holding each step
// for period+1 cycles, for a fixed number of passes or until stopped.
module led_pattern_gen #(
  parameter int WIDTH = 10,
  parameter int DIV_W = 16,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  led_pattern_gen_if.slave bus
);

  localparam int STEP_W = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] LAST_LONG  = STEP_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_SHORT = STEP_W'(1);

  localparam logic [1:0] M_BLINK = 2'b00;
  localparam logic [1:0] M_CHASE = 2'b01;
  localparam logic [1:0] M_FILL  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [WIDTH-1:0]   led_q, led_d;

  logic [STEP_W-1:0]  last_step;
  logic [REP_W-1:0]   last_pass;

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m,
                                               input logic [STEP_W-1:0] s);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (m)
        M_BLINK: p[i] = (s == {STEP_W{1'b0}});
        M_CHASE: p[i] = (i == int'(s));
        M_FILL:  p[i] = (i <= int'(s));
        default: p[i] = (i[0] == s[0]);
      endcase
    end
    return p;
  endfunction

  // BLINK and ALT are two-step patterns; CHASE and FILL walk all LEDs
  always_comb begin
    last_step = LAST_SHORT;
    if (mode_q == M_CHASE || mode_q == M_FILL) last_step = LAST_LONG;
  end

  assign last_pass = rep_q - 1'b1;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      pass_q   <= '0;
      div_q    <= '0;
      mode_q   <= '0;
      period_q <= '0;
      rep_q    <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pass_q   <= pass_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      rep_q    <= rep_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    pass_d   = pass_q;
    div_d    = div_q;
    mode_d   = mode_q;
    period_d = period_q;
    rep_d    = rep_q;
    led_d    = led_q;

    case (state_q)
      IDLE: begin
        led_d = '0;
        // stop has priority over won so a held abort can never start a run
        if (bus.won && !bus.stop) begin
          mode_d   = bus.mode;
          period_d = bus.period;
          rep_d    = bus.repeats;
          step_d   = '0;
          pass_d   = '0;
          div_d    = '0;
          led_d    = pattern(bus.mode, {STEP_W{1'b0}});
          state_d  = RUN;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          led_d   = '0;
          step_d  = '0;
          pass_d  = '0;
          div_d   = '0;
        end else if (div_q == period_q) begin
          div_d = '0;
          if (step_q == last_step) begin
            step_d = '0;
            // repeats of zero never terminates; the pass counter just wraps
            if (rep_q != '0 && pass_q == last_pass) begin
              state_d = DONE;
              led_d   = '0;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 1'b1;
              led_d  = pattern(mode_q, {STEP_W{1'b0}});
            end
          end else begin
            step_d = step_q + 1'b1;
            led_d  = pattern(mode_q, step_q + 1'b1);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        led_d   = '0;
      end

      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
  end

  assign bus.LEDR = led_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (WIDTH=10) with hand-computed LED sequences.
module tb_led_pattern_gen;

  logic clk;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  led_pattern_gen_if #(.WIDTH(10), .DIV_W(16), .REP_W(4)) bus ();

  led_pattern_gen #(.WIDTH(10), .DIV_W(16), .REP_W(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] p, input logic [3:0] r);
    bus.mode    = m;
    bus.period  = p;
    bus.repeats = r;
    bus.won     = 1'b1;
    tick();
    bus.won     = 1'b0;
  endtask

  logic [9:0] blink_exp [8]  = '{10'h3FF, 10'h3FF, 10'h000, 10'h000,
                                 10'h3FF, 10'h3FF, 10'h000, 10'h000};
  logic [9:0] chase_exp [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                 10'h020, 10'h040, 10'h080, 10'h100, 10'h200};
  logic [9:0] fill_exp  [13] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                                 10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF,
                                 10'h001, 10'h003, 10'h007};
  logic [9:0] alt_exp   [6]  = '{10'h155, 10'h155, 10'h155,
                                 10'h2AA, 10'h2AA, 10'h2AA};

  initial begin
    int busy_cnt;
    bus.won = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00;
    bus.period = '0; bus.repeats = '0;
    Reset = 1'b1;
    #2;
    check("rst_led",  32'(bus.LEDR), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    tick();
    Reset = 1'b0;
    tick();

    // BLINK, period=1, repeats=2
    start(2'b00, 16'd1, 4'd2);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("blink_led%0d", k), 32'(bus.LEDR), 32'(blink_exp[k]));
      busy_cnt += int'(bus.busy);
      check("blink_nodone", 32'(bus.done), 32'h0);
      tick();
    end
    check("blink_busycnt", 32'(busy_cnt), 32'd8);
    check("blink_end_led",  32'(bus.LEDR), 32'h0);
    check("blink_done",     32'(bus.done), 32'h1);
    check("blink_end_busy", 32'(bus.busy), 32'h0);
    tick();
    check("blink_done_clr", 32'(bus.done), 32'h0);
    tick();

    // CHASE, period=0, repeats=1
    start(2'b01, 16'd0, 4'd1);
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("chase_led%0d", k), 32'(bus.LEDR), 32'(chase_exp[k]));
      busy_cnt += int'(bus.busy);
      tick();
    end
    check("chase_busycnt", 32'(busy_cnt), 32'd10);
    check("chase_done",    32'(bus.done), 32'h1);
    check("chase_end_led", 32'(bus.LEDR), 32'h0);
    tick();
    check("chase_done_clr", 32'(bus.done), 32'h0);

    // FILL, repeats=0 (endless), abort after 13 cycles
    start(2'b10, 16'd0, 4'd0);
    for (int k = 0; k < 13; k++) begin
      check($sformatf("fill_led%0d", k), 32'(bus.LEDR), 32'(fill_exp[k]));
      check("fill_nodone", 32'(bus.done), 32'h0);
      if (k < 12) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("fill_stop_led",  32'(bus.LEDR), 32'h0);
    check("fill_stop_busy", 32'(bus.busy), 32'h0);
    check("fill_stop_done", 32'(bus.done), 32'h0);
    tick();
    check("fill_stop_done2", 32'(bus.done), 32'h0);

    // ALT, period=2, repeats=1, with won re-pulsed mid-run using other settings
    start(2'b11, 16'd2, 4'd1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("alt_led%0d", k), 32'(bus.LEDR), 32'(alt_exp[k]));
      if (k == 1 || k == 4) begin
        bus.mode = 2'b01; bus.period = 16'd0; bus.repeats = 4'd3;
        bus.won = 1'b1;
      end else begin
        bus.won = 1'b0;
      end
      tick();
    end
    check("alt_done", 32'(bus.done), 32'h1);
    bus.won = 1'b1;
    tick();
    bus.won = 1'b0;
    check("alt_won_in_done_busy", 32'(bus.busy), 32'h0);
    check("alt_won_in_done_led",  32'(bus.LEDR), 32'h0);
    tick();

    // Asynchronous reset between edges mid-CHASE, then a clean restart
    start(2'b01, 16'd0, 4'd1);
    tick(); tick();
    check("rst_mid_pre", 32'(bus.LEDR), 32'h004);
    #3 Reset = 1'b1;
    #1;
    check("rst_mid_led",  32'(bus.LEDR), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    #2 Reset = 1'b0;
    tick();
    check("rst_idle_busy", 32'(bus.busy), 32'h0);
    start(2'b01, 16'd0, 4'd1);
    check("restart_led0", 32'(bus.LEDR), 32'h001);
    check("restart_busy", 32'(bus.busy), 32'h1);
    tick();
    check("restart_led1", 32'(bus.LEDR), 32'h002);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("restart_stop_led", 32'(bus.LEDR), 32'h0);

    // won and stop together in IDLE: no run
    bus.mode = 2'b00; bus.period = 16'd0; bus.repeats = 4'd1;
    bus.won = 1'b1; bus.stop = 1'b1;
    tick();
    check("wonstop_busy0", 32'(bus.busy), 32'h0);
    check("wonstop_led0",  32'(bus.LEDR), 32'h0);
    tick();
    check("wonstop_busy1", 32'(bus.busy), 32'h0);
    bus.won = 1'b0; bus.stop = 1'b0;
    tick();
    check("wonstop_after", 32'(bus.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
